// File: rtl/call_ret_ctrl_if.sv
// Bus between the call/return sequencer and the return-address stack.
// The sequencer is the master: it drives en/con/data_in and reads data_out/full.
interface call_ret_ctrl_if #(
   parameter int width = 8
);
   logic             en;
   logic             con;
   logic [width-1:0] data_in;
   logic [width-1:0] data_out;
   logic             full;

   modport master (output en, output con, output data_in, input data_out, input full);
   modport slave  (input en, input con, input data_in, output data_out, output full);
endinterface

// File: rtl/call_ret_ctrl.sv
// Call/return sequencer: pushes the return address and jumps on call, pops it back into
// the PC on return, and tracks stack occupancy to flag overflow and underflow.
module call_ret_ctrl #(
   parameter int width = 8,
   parameter int depth = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             call,
   input  logic             ret,
   input  logic [width-1:0] ret_addr,
   input  logic [width-1:0] target,
   call_ret_ctrl_if.master  stk,
   output logic [width-1:0] pc_out,
   output logic             pc_load,
   output logic             busy,
   output logic             overflow,
   output logic             underflow,
   output logic [depth:0]   level
);

   typedef enum logic [1:0] {IDLE, PUSH, POP, WAIT} state_t;

   localparam logic [depth:0] FULL_LVL = (depth+1)'(2**depth);
   localparam logic [depth:0] ONE_LVL  = (depth+1)'(1);

   state_t           state, state_nxt;
   logic [depth:0]   level_nxt;
   logic [width-1:0] pc_nxt;
   logic             load_nxt, ovf_nxt, unf_nxt;
   logic [width-1:0] ret_lat, ret_lat_nxt;
   logic [width-1:0] tgt_lat, tgt_lat_nxt;

   always_ff @(posedge clk) begin
      if (!clr) begin
         state     <= IDLE;
         level     <= '0;
         pc_out    <= '0;
         pc_load   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         ret_lat   <= '0;
         tgt_lat   <= '0;
      end else begin
         state     <= state_nxt;
         level     <= level_nxt;
         pc_out    <= pc_nxt;
         pc_load   <= load_nxt;
         overflow  <= ovf_nxt;
         underflow <= unf_nxt;
         ret_lat   <= ret_lat_nxt;
         tgt_lat   <= tgt_lat_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      level_nxt   = level;
      pc_nxt      = pc_out;
      load_nxt    = 1'b0;
      ovf_nxt     = 1'b0;
      unf_nxt     = 1'b0;
      ret_lat_nxt = ret_lat;
      tgt_lat_nxt = tgt_lat;
      stk.en      = 1'b0;
      stk.con     = 1'b0;

      case (state)
         IDLE: begin
            // call wins over a simultaneous ret; the ret is simply dropped
            if (call) begin
               if (level == FULL_LVL || stk.full) begin
                  ovf_nxt = 1'b1;
               end else begin
                  ret_lat_nxt = ret_addr;
                  tgt_lat_nxt = target;
                  state_nxt   = PUSH;
               end
            end else if (ret) begin
               if (level == '0) begin
                  unf_nxt = 1'b1;
               end else begin
                  state_nxt = POP;
               end
            end
         end
         PUSH: begin
            stk.en    = 1'b1;
            pc_nxt    = tgt_lat;
            load_nxt  = 1'b1;
            level_nxt = level + ONE_LVL;
            state_nxt = IDLE;
         end
         POP: begin
            stk.en    = 1'b1;
            stk.con   = 1'b1;
            level_nxt = level - ONE_LVL;
            state_nxt = WAIT;
         end
         WAIT: begin
            // popped word only appears on data_out one cycle after the pop edge
            pc_nxt    = stk.data_out;
            load_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stk.data_in = ret_lat;
   assign busy        = (state != IDLE);

endmodule
